wptr_full_sync: RTL and testbench

- Write-side pointer manager for the async FIFO.
- Owns the write pointer (binary and gray) and synchronises the read-domain gray pointer through a parametrised flop chain.
- Decodes the synchronised pointer to binary and produces registered fill level, full, almost-full and sticky overflow status.
- Sits in the write clock domain between the FIFO memory write port and the read-pointer crossing. Generalises the fixed 2-flop read-pointer synchroniser.

---
 rtl/wptr_full_sync.sv | 160 ++++++++++++++++
 tb/tb_wptr_full_sync.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wptr_full_sync.sv
`default_nettype none
// ============================================================================
// Module   : wptr_full_sync
// Brief    : Write-domain pointer manager for the async FIFO. It holds the
//            write pointer and synchronises the read gray pointer, then
//            produces registered fill level, full, almost-full and overflow.
//            Optional gray-step checker: define WPTR_GRAY_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wptr_full_sync #(
    parameter int address      = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 6
) (
    input  logic               write_clk,
    input  logic               write_rst,
    input  logic               write_en,
    input  logic               clear_overflow,
    input  logic [address:0]   read_ptr_gray,
    output logic               write_ack,
    output logic [address-1:0] write_addr,
    output logic [address:0]   write_ptr_gray,
    output logic [address:0]   sync_read_ptr,
    output logic [address:0]   fill_level,
    output logic               full,
    output logic               almost_full,
    output logic               overflow,
    output logic               gray_err
);

    localparam logic [address:0] c_depth = {1'b1, {address{1'b0}}};
    localparam logic [address:0] c_one   = {{address{1'b0}}, 1'b1};
    localparam int               c_thr   = AFULL_THRESH;
    localparam logic [address:0] c_afull = c_thr[address:0];

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("wptr_full_sync: SYNC_STAGES must be at least 2");
        end
        if (AFULL_THRESH < 1 || AFULL_THRESH > (1 << address)) begin : g_bad_afull
            $error("wptr_full_sync: AFULL_THRESH must lie in 1..2^address");
        end
    endgenerate

    function automatic logic [address:0] gray2bin(input logic [address:0] g);
        logic [address:0] b;
        b[address] = g[address];
        for (int i = address - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [address:0] r_wbin;
    logic [address:0] r_wgray;
    logic [address:0] r_sync_read_ptr;
    logic [address:0] r_fill_level;
    logic             r_full;
    logic             r_almost_full;
    logic             r_overflow;
    logic [address:0] r_sync [SYNC_STAGES];

    logic             w_write_ack;
    logic [address:0] w_wbin_next;
    logic [address:0] w_last;
    logic [address:0] w_rbin;
    logic [address:0] w_fill_next;

    // Refusal is based on the registered full flag, so a refused write never
    // advances the pointer.
    assign w_write_ack = write_en & ~r_full;
    assign w_wbin_next = r_wbin + (w_write_ack ? c_one : '0);
    assign w_last      = r_sync[SYNC_STAGES-1];
    assign w_rbin      = gray2bin(w_last);
    assign w_fill_next = w_wbin_next - w_rbin;

    generate
        for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync
            if (s == 0) begin : g_first
                always_ff @(posedge write_clk or posedge write_rst) begin
                    if (write_rst) begin
                        r_sync[s] <= '0;
                    end else begin
                        r_sync[s] <= read_ptr_gray;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge write_clk or posedge write_rst) begin
                    if (write_rst) begin
                        r_sync[s] <= '0;
                    end else begin
                        r_sync[s] <= r_sync[s-1];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge write_clk or posedge write_rst) begin
        if (write_rst) begin
            r_wbin          <= '0;
            r_wgray         <= '0;
            r_sync_read_ptr <= '0;
            r_fill_level    <= '0;
            r_full          <= 1'b0;
            r_almost_full   <= 1'b0;
            r_overflow      <= 1'b0;
        end else begin
            r_wbin          <= w_wbin_next;
            r_wgray         <= w_wbin_next ^ (w_wbin_next >> 1);
            r_sync_read_ptr <= w_rbin;
            // Status looks at the post-write pointer so full rises on the
            // very edge that consumes the last free slot.
            r_fill_level    <= w_fill_next;
            r_full          <= (w_fill_next == c_depth);
            r_almost_full   <= (w_fill_next >= c_afull);
            if (write_en && r_full) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef WPTR_GRAY_CHECK_EN
    logic [address:0] r_last_prev;
    logic             r_gray_err;
    logic [address:0] w_step;

    assign w_step = w_last ^ r_last_prev;

    // x & (x-1) is nonzero exactly when more than one bit of x is set.
    always_ff @(posedge write_clk or posedge write_rst) begin
        if (write_rst) begin
            r_last_prev <= '0;
            r_gray_err  <= 1'b0;
        end else begin
            r_last_prev <= w_last;
            if ((w_step & (w_step - c_one)) != '0) begin
                r_gray_err <= 1'b1;
            end
        end
    end

    assign gray_err = r_gray_err;
`else
    assign gray_err = 1'b0;
`endif

    assign write_ack      = w_write_ack;
    assign write_addr     = r_wbin[address-1:0];
    assign write_ptr_gray = r_wgray;
    assign sync_read_ptr  = r_sync_read_ptr;
    assign fill_level     = r_fill_level;
    assign full           = r_full;
    assign almost_full    = r_almost_full;
    assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_wptr_full_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_wptr_full_sync
// Brief    : Directed scoreboard bench for wptr_full_sync (address=3,
//            SYNC_STAGES=2, AFULL_THRESH=6).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wptr_full_sync;

    localparam int A = 3;

    localparam int S_ACK  = 0;
    localparam int S_ADDR = 1;
    localparam int S_WPG  = 2;
    localparam int S_SRP  = 3;
    localparam int S_FILL = 4;
    localparam int S_FULL = 5;
    localparam int S_AF   = 6;
    localparam int S_OVF  = 7;
    localparam int S_GERR = 8;

`ifdef WPTR_GRAY_CHECK_EN
    localparam logic [31:0] c_gerr_jump = 32'd1;
`else
    localparam logic [31:0] c_gerr_jump = 32'd0;
`endif

    logic         write_clk = 1'b0;
    logic         write_rst;
    logic         write_en;
    logic         clear_overflow;
    logic [A:0]   read_ptr_gray;
    logic         write_ack;
    logic [A-1:0] write_addr;
    logic [A:0]   write_ptr_gray;
    logic [A:0]   sync_read_ptr;
    logic [A:0]   fill_level;
    logic         full;
    logic         almost_full;
    logic         overflow;
    logic         gray_err;

    wptr_full_sync #(
        .address      (A),
        .SYNC_STAGES  (2),
        .AFULL_THRESH (6)
    ) dut (
        .write_clk      (write_clk),
        .write_rst      (write_rst),
        .write_en       (write_en),
        .clear_overflow (clear_overflow),
        .read_ptr_gray  (read_ptr_gray),
        .write_ack      (write_ack),
        .write_addr     (write_addr),
        .write_ptr_gray (write_ptr_gray),
        .sync_read_ptr  (sync_read_ptr),
        .fill_level     (fill_level),
        .full           (full),
        .almost_full    (almost_full),
        .overflow       (overflow),
        .gray_err       (gray_err)
    );

    always #5 write_clk = ~write_clk;

    typedef struct {
        string       tag;
        int          id;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [A:0] g(input int b);
        logic [A:0] x;
        x = b[A:0];
        return x ^ (x >> 1);
    endfunction

    function automatic logic [31:0] obs(input int id);
        case (id)
            S_ACK:   return 32'(write_ack);
            S_ADDR:  return 32'(write_addr);
            S_WPG:   return 32'(write_ptr_gray);
            S_SRP:   return 32'(sync_read_ptr);
            S_FILL:  return 32'(fill_level);
            S_FULL:  return 32'(full);
            S_AF:    return 32'(almost_full);
            S_OVF:   return 32'(overflow);
            S_GERR:  return 32'(gray_err);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int id, input logic [31:0] v);
        sb.push_back('{tag, id, v});
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.id);
            vectors++;
            assert (o === e.val) else begin
                miscompares++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic expect_all_zero(input string tag);
        expect_val({tag, ".ack"},  S_ACK,  0);
        expect_val({tag, ".addr"}, S_ADDR, 0);
        expect_val({tag, ".wpg"},  S_WPG,  0);
        expect_val({tag, ".srp"},  S_SRP,  0);
        expect_val({tag, ".fill"}, S_FILL, 0);
        expect_val({tag, ".full"}, S_FULL, 0);
        expect_val({tag, ".af"},   S_AF,   0);
        expect_val({tag, ".ovf"},  S_OVF,  0);
        expect_val({tag, ".gerr"}, S_GERR, 0);
        check_all();
    endtask

    task automatic step();
        @(posedge write_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        write_rst      = 1'b1;
        write_en       = 1'b0;
        clear_overflow = 1'b0;
        read_ptr_gray  = '0;
        step();
        step();
        expect_all_zero("reset");
        write_rst = 1'b0;

        // Fill from empty with the read pointer parked at 0.
        for (int i = 1; i <= 8; i++) begin
            write_en = 1'b1;
            #1;
            expect_val($sformatf("fill%0d.ack", i), S_ACK, 1);
            expect_val($sformatf("fill%0d.addr", i), S_ADDR, 32'(i - 1));
            check_all();
            step();
            expect_val($sformatf("fill%0d.level", i), S_FILL, 32'(i));
            expect_val($sformatf("fill%0d.full", i), S_FULL, (i == 8) ? 1 : 0);
            expect_val($sformatf("fill%0d.af", i), S_AF, (i >= 6) ? 1 : 0);
            expect_val($sformatf("fill%0d.wpg", i), S_WPG, 32'(g(i)));
            check_all();
        end

        write_en = 1'b1;
        #1;
        expect_val("ninth.ack", S_ACK, 0);
        check_all();
        step();
        expect_val("ninth.ovf",  S_OVF,  1);
        expect_val("ninth.wpg",  S_WPG,  32'b1100);
        expect_val("ninth.fill", S_FILL, 8);
        expect_val("ninth.full", S_FULL, 1);
        check_all();

        clear_overflow = 1'b1;
        step();
        expect_val("setwins.ovf", S_OVF, 1);
        expect_val("setwins.wpg", S_WPG, 32'b1100);
        check_all();
        write_en = 1'b0;
        step();
        expect_val("clear.ovf", S_OVF, 0);
        check_all();
        clear_overflow = 1'b0;

        // One read: full must hold for exactly two more edges, then drop.
        read_ptr_gray = 4'b0001;
        step();
        expect_val("rd.lat1.full", S_FULL, 1);
        check_all();
        step();
        expect_val("rd.lat2.full", S_FULL, 1);
        check_all();
        step();
        expect_val("rd.lat3.full", S_FULL, 0);
        expect_val("rd.lat3.fill", S_FILL, 7);
        expect_val("rd.lat3.srp",  S_SRP,  1);
        expect_val("rd.lat3.af",   S_AF,   1);
        check_all();

        read_ptr_gray = 4'b0011;
        step();
        read_ptr_gray = 4'b0010;
        step();
        step();
        step();
        expect_val("fill5.fill", S_FILL, 5);
        expect_val("fill5.af",   S_AF,   0);
        expect_val("fill5.srp",  S_SRP,  3);
        check_all();

        // Asynchronous reset between edges.
        #3;
        write_rst = 1'b1;
        #1;
        expect_all_zero("midrst");
        read_ptr_gray = '0;
        step();
        step();
        write_rst = 1'b0;
        step();
        expect_val("postrst.wpg",  S_WPG,  0);
        expect_val("postrst.fill", S_FILL, 0);
        check_all();

        // Continuous writes across the pointer wrap; the read pointer leads
        // so that, after the synchroniser lag, it sits two behind.
        for (int m = 0; m < 20; m++) begin
            write_en      = 1'b1;
            read_ptr_gray = g(m + 1);
            #1;
            expect_val($sformatf("wrap%0d.ack", m), S_ACK, 1);
            expect_val($sformatf("wrap%0d.addr", m), S_ADDR, 32'(m % 8));
            check_all();
            step();
            expect_val($sformatf("wrap%0d.wpg", m), S_WPG, 32'(g(m + 1)));
            expect_val($sformatf("wrap%0d.fill", m), S_FILL, (m == 0) ? 1 : 2);
            expect_val($sformatf("wrap%0d.full", m), S_FULL, 0);
            check_all();
        end
        write_en = 1'b0;

        // Two-bit jump on the read gray pointer.
        write_rst     = 1'b1;
        read_ptr_gray = '0;
        step();
        write_rst = 1'b0;
        step();
        step();
        read_ptr_gray = 4'b0011;
        step();
        step();
        expect_val("jump.early.gerr", S_GERR, 0);
        check_all();
        step();
        expect_val("jump.gerr", S_GERR, c_gerr_jump);
        expect_val("jump.srp",  S_SRP,  2);
        check_all();

        // Legal single-bit steps must never flag.
        write_rst     = 1'b1;
        read_ptr_gray = '0;
        step();
        write_rst = 1'b0;
        step();
        step();
        read_ptr_gray = 4'b0001;
        step();
        read_ptr_gray = 4'b0011;
        step();
        step();
        step();
        step();
        expect_val("single.gerr", S_GERR, 0);
        expect_val("single.srp",  S_SRP,  2);
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
